// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the ID/EX pipeline stage register: bundle field widths,
// packing order (opcode in the MSBs) and occupancy width.
package pipe_stage_reg_pkg;

  localparam int OPCODE_W = 7;
  localparam int FUNCT3_W = 3;
  localparam int FUNCT7_W = 7;
  localparam int REG_W    = 5;
  localparam int IMM_W    = 32;
  localparam int LWSW_W   = 2;

  localparam int ID_EX_W  = OPCODE_W + FUNCT3_W + FUNCT7_W + 3 * REG_W + IMM_W + LWSW_W + 4;
  localparam int OCC_W    = 2;

  // Field order is the packing order: the first member lands in the MSBs.
  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [FUNCT3_W-1:0] funct3;
    logic [FUNCT7_W-1:0] funct7;
    logic [REG_W-1:0]    src1;
    logic [REG_W-1:0]    src2;
    logic [REG_W-1:0]    dest;
    logic [IMM_W-1:0]    imm;
    logic [LWSW_W-1:0]   lw_sw;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                mem_to_reg;
  } id_ex_t;

  function automatic id_ex_t unpack_id_ex(input logic [ID_EX_W-1:0] i_bits);
    return id_ex_t'(i_bits);
  endfunction

endpackage

// File: rtl/skid_slot.sv
// One-entry holding register with a valid bit; load captures data, clear drops
// the valid bit but leaves the payload untouched.
module skid_slot
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W = ID_EX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      if (i_clear)     r_valid <= 1'b0;
      else if (i_load) r_valid <= 1'b1;
      if (i_load)      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register. SKID_EN=1 adds a skid slot so in_ready can
// come straight from a flop; SKID_EN=0 is a single register with combinational ready.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W  = ID_EX_W,
  parameter bit SKID_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occupancy
);

  logic              r_main_valid;
  logic [DATA_W-1:0] r_main_data;
  logic              w_skid_valid;
  logic [DATA_W-1:0] w_skid_data;
  logic              w_in_xfer;
  logic              w_out_xfer;

  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_main_valid && out_ready;
  assign occupancy  = OCC_W'(r_main_valid) + OCC_W'(w_skid_valid);

  generate
    if (SKID_EN) begin : g_skid
      logic             r_in_ready;
      logic [OCC_W-1:0] w_occ_next;

      // NOTE: default assignment first, so no path through this block infers a latch.
      always_comb begin
        w_occ_next = occupancy;
        if (flush)                         w_occ_next = '0;
        else if (w_in_xfer && !w_out_xfer) w_occ_next = occupancy + OCC_W'(1);
        else if (!w_in_xfer && w_out_xfer) w_occ_next = occupancy - OCC_W'(1);
      end

      always_ff @(posedge clk) begin
        if (rst) r_in_ready <= 1'b1;
        else     r_in_ready <= (w_occ_next != OCC_W'(2));
      end

      // The skid slot only fills when main is held and not draining this cycle.
      skid_slot #(.DATA_W(DATA_W)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_in_xfer && r_main_valid && !w_out_xfer && !flush),
        .i_clear (flush || w_out_xfer),
        .i_data  (in_data),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data)
      );

      assign in_ready = r_in_ready;
    end else begin : g_noskid
      assign w_skid_valid = 1'b0;
      assign w_skid_data  = '0;
      assign in_ready     = !r_main_valid || out_ready;
    end
  endgenerate

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_valid <= 1'b0;
      // NOTE: payload is reset so out_data reads zero after reset; flush leaves it alone.
      r_main_data  <= '0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
    end else if (w_out_xfer && w_skid_valid) begin
      r_main_data  <= w_skid_data;
    end else if (w_in_xfer && (!r_main_valid || w_out_xfer)) begin
      r_main_valid <= 1'b1;
      r_main_data  <= in_data;
    end else if (w_out_xfer) begin
      r_main_valid <= 1'b0;
    end
  end

  assign out_valid = r_main_valid;
  assign out_data  = r_main_data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Runs the skid and non-skid variants side by side on shared stimulus, each against
// its own in-order queue model of the stage.
module tb_pipe_stage_reg;

  localparam int W = 70;
  typedef logic [W-1:0] data_t;

  logic  clk = 1'b0;
  always #5 clk = ~clk;

  logic  rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  data_t in_data = '0;

  logic  in_ready_s, out_valid_s, in_ready_n, out_valid_n;
  data_t out_data_s, out_data_n;
  logic [1:0] occ_s, occ_n;

  pipe_stage_reg #(.DATA_W(W), .SKID_EN(1'b1)) dut_skid (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_data(out_data_s), .occupancy(occ_s)
  );

  pipe_stage_reg #(.DATA_W(W), .SKID_EN(1'b0)) dut_noskid (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_n),
    .in_data(in_data), .out_valid(out_valid_n), .out_ready(out_ready),
    .out_data(out_data_n), .occupancy(occ_n)
  );

  int    n_checks = 0;
  int    n_errors = 0;
  data_t q_s[$];
  data_t q_n[$];
  bit    known = 1'b0, zero_s = 1'b0, zero_n = 1'b0;

  task automatic check(input string tag, input data_t got, input data_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic data_t rnd_data();
    return {6'($urandom), $urandom, $urandom};
  endfunction

  task automatic check_outputs();
    check("s_valid", data_t'(out_valid_s), data_t'(q_s.size() != 0));
    check("s_occ",   data_t'(occ_s),       data_t'(q_s.size()));
    if (q_s.size() != 0) check("s_data", out_data_s, q_s[0]);
    else if (zero_s)     check("s_data_rst", out_data_s, '0);
    check("n_valid", data_t'(out_valid_n), data_t'(q_n.size() != 0));
    check("n_occ",   data_t'(occ_n),       data_t'(q_n.size()));
    if (q_n.size() != 0) check("n_data", out_data_n, q_n[0]);
    else if (zero_n)     check("n_data_rst", out_data_n, '0);
  endtask

  // One clock: outputs are checked with the in_*/out_ready inputs inverted (so any
  // combinational in->out path shows up), then in_ready with the real inputs, then
  // both queue models advance on the rising edge.
  task automatic step();
    logic  sv, sr;
    data_t sd;
    bit    acc_s, acc_n, pop_s, pop_n;
    @(negedge clk);
    if (known) begin
      sv = in_valid; sr = out_ready; sd = in_data;
      in_valid = ~sv; out_ready = ~sr; in_data = ~sd;
      #1;
      check_outputs();
      in_valid = sv; out_ready = sr; in_data = sd;
      #1;
      check("s_ready", data_t'(in_ready_s), data_t'(q_s.size() < 2));
      check("n_ready", data_t'(in_ready_n), data_t'(q_n.size() == 0 || out_ready));
    end
    @(posedge clk);
    acc_s = in_valid && (q_s.size() < 2);
    acc_n = in_valid && (q_n.size() == 0 || out_ready);
    pop_s = out_ready && (q_s.size() != 0);
    pop_n = out_ready && (q_n.size() != 0);
    if (rst) begin
      q_s.delete(); q_n.delete();
      known = 1'b1; zero_s = 1'b1; zero_n = 1'b1;
    end else if (flush) begin
      q_s.delete(); q_n.delete();
    end else begin
      if (pop_s) void'(q_s.pop_front());
      if (pop_n) void'(q_n.pop_front());
      if (acc_s) begin q_s.push_back(in_data); zero_s = 1'b0; end
      if (acc_n) begin q_n.push_back(in_data); zero_n = 1'b0; end
    end
    #1;
  endtask

  initial begin
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();

    // Back-to-back stream at full rate.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = data_t'(i);
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    check("stream_drained", data_t'(occ_s), '0);

    // Backpressure: two accepted, third refused, head held.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = data_t'(8'hA1); step();
    in_data = data_t'(8'hA2); step();
    in_data = data_t'(8'hA3); step();
    step();
    check("bp_occ",   data_t'(occ_s),      data_t'(2));
    check("bp_ready", data_t'(in_ready_s), '0);
    check("bp_head",  out_data_s,          data_t'(8'hA1));
    out_ready = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // Flush while full with a payload on the input.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = data_t'(8'h11); step();
    in_data = data_t'(8'h12); step();
    flush = 1'b1; in_data = data_t'(8'hFF); step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_valid", data_t'(out_valid_s), '0);
    check("fl_occ",   data_t'(occ_s),       '0);
    check("fl_ready", data_t'(in_ready_s),  data_t'(1));
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Reset mid-stream at occupancy 1.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = data_t'(8'h33); step();
    in_valid = 1'b0; step();
    rst = 1'b1; in_valid = 1'b1; in_data = data_t'(8'h44); step();
    rst = 1'b0; in_valid = 1'b0;
    check("rst_valid", data_t'(out_valid_s), '0);
    check("rst_data",  out_data_s,           '0);
    in_valid = 1'b1; in_data = data_t'(8'h55); step();
    in_valid = 1'b0; step();
    check("rst_next", out_data_s, data_t'(8'h55));
    out_ready = 1'b1;
    step();
    step();

    // Random valid/ready, no flush.
    for (int c = 0; c < 1000; c++) begin
      in_valid = 1'($urandom); out_ready = 1'($urandom); in_data = rnd_data();
      step();
    end

    // Random valid/ready with occasional flush and rare reset.
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      in_data   = rnd_data();
      flush     = ($urandom_range(15, 0) == 0);
      rst       = ($urandom_range(511, 0) == 0);
      step();
    end
    flush = 1'b0; rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
